// File: rtl/ddr_arb_pkg.sv
// Shared types and widths for the DDR write-command arbiter.
// Holds the FSM state encoding and the round-robin pointer advance helper.
package ddr_arb_pkg;

   localparam int ADDR_W = 23;
   localparam int LEN_W  = 10;
   localparam int IDX_W  = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARB     = 3'd1,
      ST_CMD     = 3'd2,
      ST_WAIT    = 3'd3,
      ST_RELEASE = 3'd4
   } arb_state_e;

   // Next round-robin start index after slave idx, wrapping at n slaves.
   function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
      if (int'(idx) >= n - 1) begin
         return '0;
      end else begin
         return idx + 2'd1;
      end
   endfunction

endpackage

// File: rtl/ddr_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr_i, wrapping at N.
// Combinational only; the caller registers the result.
module rr_pick_first
   import ddr_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             found_o
);

   logic [IDX_W-1:0] cand_s;

   // Scan from the farthest offset back to ptr_i so the nearest requester wins.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      cand_s  = '0;
      for (int off = N - 1; off >= 0; off--) begin
         cand_s = IDX_W'((int'(ptr_i) + off) % N);
         if (req_i[cand_s]) begin
            idx_o   = cand_s;
            found_o = 1'b1;
         end else begin
            found_o = found_o;
         end
      end
   end

endmodule

// File: rtl/ddr_wr_arbiter.sv
// Round-robin arbiter and command sequencer sharing one DDR write-command port
// among up to four slave write channels, holding each grant until burst done.
module ddr_wr_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int         NUM_SLAVES     = 4,
   parameter int         HOLDOFF_CYCLES = 3,
   parameter logic [3:0] SLAVE_EN_MASK  = 4'b1111
) (
   input  logic                         ddr_clk,
   input  logic                         sys_rstn,
   input  logic [NUM_SLAVES-1:0]        slave_req,
   input  logic [ADDR_W*NUM_SLAVES-1:0] slave_waddr_bus,
   input  logic [LEN_W*NUM_SLAVES-1:0]  slave_wburst_len_bus,
   output logic [NUM_SLAVES-1:0]        arbitrate_valid,
   output logic [IDX_W-1:0]             slave_wrbank,
   output logic                         ddr_wr_cmd_req,
   input  logic                         ddr_wr_cmd_ack,
   output logic [ADDR_W-1:0]            ddr_waddr,
   output logic [LEN_W-1:0]             ddr_wburst_len,
   input  logic                         ddr_wr_done,
   output logic                         arb_busy
);

   localparam int CNT_W = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES);

   arb_state_e              state_q, state_d;
   logic [NUM_SLAVES-1:0]   valid_q, valid_d;
   logic [IDX_W-1:0]        bank_q, bank_d;
   logic                    cmd_req_q, cmd_req_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [IDX_W-1:0]        rr_q, rr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    busy_q;

   logic [NUM_SLAVES-1:0]   act_req_s;
   logic [IDX_W-1:0]        pick_idx_s;
   logic                    pick_found_s;
   logic [ADDR_W-1:0]       sel_addr_s;
   logic [LEN_W-1:0]        sel_len_s;

   assign act_req_s  = slave_req & SLAVE_EN_MASK[NUM_SLAVES-1:0];
   assign sel_addr_s = slave_waddr_bus[int'(pick_idx_s)*ADDR_W +: ADDR_W];
   assign sel_len_s  = slave_wburst_len_bus[int'(pick_idx_s)*LEN_W +: LEN_W];

   rr_pick_first #(
      .N (NUM_SLAVES)
   ) u_pick (
      .req_i   (act_req_s),
      .ptr_i   (rr_q),
      .idx_o   (pick_idx_s),
      .found_o (pick_found_s)
   );

   // Next-state and registered-output decode.
   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      bank_d    = bank_q;
      cmd_req_d = cmd_req_q;
      addr_d    = addr_q;
      len_d     = len_q;
      rr_d      = rr_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|act_req_s) begin
               state_d = ST_ARB;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARB: begin
            // A requester may have withdrawn since IDLE; fall back if none remain.
            if (pick_found_s) begin
               bank_d  = pick_idx_s;
               valid_d = NUM_SLAVES'(1) << pick_idx_s;
               addr_d  = sel_addr_s;
               len_d   = sel_len_s;
               if (sel_len_s == {LEN_W{1'b0}}) begin
                  state_d = ST_RELEASE;
                  cnt_d   = '0;
               end else begin
                  state_d   = ST_CMD;
                  cmd_req_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CMD: begin
            if (ddr_wr_cmd_ack) begin
               cmd_req_d = 1'b0;
               if (ddr_wr_done) begin
                  state_d = ST_RELEASE;
                  valid_d = '0;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_WAIT;
               end
            end else begin
               cmd_req_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (ddr_wr_done) begin
               state_d = ST_RELEASE;
               valid_d = '0;
               cnt_d   = '0;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RELEASE: begin
            // A zero-length grant enters here with valid set; it clears after one cycle.
            valid_d   = '0;
            cmd_req_d = 1'b0;
            rr_d      = rr_next(bank_q, NUM_SLAVES);
            if (int'(cnt_q) + 1 >= HOLDOFF_CYCLES) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            valid_d   = '0;
            cmd_req_d = 1'b0;
            cnt_d     = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge ddr_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state_q   <= ST_IDLE;
         valid_q   <= '0;
         bank_q    <= '0;
         cmd_req_q <= 1'b0;
         addr_q    <= '0;
         len_q     <= '0;
         rr_q      <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         bank_q    <= bank_d;
         cmd_req_q <= cmd_req_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         rr_q      <= rr_d;
         cnt_q     <= cnt_d;
         busy_q    <= (state_d != ST_IDLE);
      end
   end

   assign arbitrate_valid = valid_q;
   assign slave_wrbank    = bank_q;
   assign ddr_wr_cmd_req  = cmd_req_q;
   assign ddr_waddr       = addr_q;
   assign ddr_wburst_len  = len_q;
   assign arb_busy        = busy_q;

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Directed bench for ddr_wr_arbiter: single grant, holdoff, round robin,
// ack+done collapse, zero-length burst, enable mask and asynchronous reset.
module tb_ddr_wr_arbiter;

   logic        ddr_clk = 1'b0;
   logic        sys_rstn;
   logic [3:0]  slave_req;
   logic [91:0] waddr_bus;
   logic [39:0] len_bus;
   logic [3:0]  valid;
   logic [1:0]  wrbank;
   logic        cmd_req;
   logic        cmd_ack;
   logic [22:0] waddr;
   logic [9:0]  wlen;
   logic        wr_done;
   logic        busy;

   logic [3:0]  m_req;
   logic [3:0]  m_valid;
   logic [1:0]  m_wrbank;
   logic        m_cmd_req;
   logic [22:0] m_waddr;
   logic [9:0]  m_wlen;
   logic        m_busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [22:0] exp_addr [4] = '{23'h000100, 23'h100100, 23'h200200, 23'h300300};
   logic [9:0]  exp_len  [4] = '{10'd256, 10'd20, 10'd30, 10'd40};

   always #5 ddr_clk = ~ddr_clk;

   ddr_wr_arbiter dut (
      .ddr_clk              (ddr_clk),
      .sys_rstn             (sys_rstn),
      .slave_req            (slave_req),
      .slave_waddr_bus      (waddr_bus),
      .slave_wburst_len_bus (len_bus),
      .arbitrate_valid      (valid),
      .slave_wrbank         (wrbank),
      .ddr_wr_cmd_req       (cmd_req),
      .ddr_wr_cmd_ack       (cmd_ack),
      .ddr_waddr            (waddr),
      .ddr_wburst_len       (wlen),
      .ddr_wr_done          (wr_done),
      .arb_busy             (busy)
   );

   ddr_wr_arbiter #(.SLAVE_EN_MASK(4'b1101)) dut_mask (
      .ddr_clk              (ddr_clk),
      .sys_rstn             (sys_rstn),
      .slave_req            (m_req),
      .slave_waddr_bus      (waddr_bus),
      .slave_wburst_len_bus (len_bus),
      .arbitrate_valid      (m_valid),
      .slave_wrbank         (m_wrbank),
      .ddr_wr_cmd_req       (m_cmd_req),
      .ddr_wr_cmd_ack       (1'b0),
      .ddr_waddr            (m_waddr),
      .ddr_wburst_len       (m_wlen),
      .ddr_wr_done          (1'b0),
      .arb_busy             (m_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ddr_clk);
      #1;
   endtask

   task automatic do_reset();
      slave_req = 4'b0000;
      cmd_ack   = 1'b0;
      wr_done   = 1'b0;
      sys_rstn  = 1'b0;
      tick();
      tick();
      sys_rstn  = 1'b1;
   endtask

   task automatic wait_grant(input string tag);
      int n;
      n = 0;
      while (valid == 4'b0000 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 32'(n < 20), 32'd1);
   endtask

   task automatic serve(input int b);
      wait_grant("rr_grant_wait");
      chk("rr_valid", 32'(valid), 32'd1 << b);
      chk("rr_bank", 32'(wrbank), 32'(b));
      chk("rr_addr", 32'(waddr), 32'(exp_addr[b]));
      chk("rr_len", 32'(wlen), 32'(exp_len[b]));
      chk("rr_cmd_req", 32'(cmd_req), 32'd1);
      cmd_ack = 1'b1;
      tick();
      cmd_ack = 1'b0;
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      chk("rr_valid_drop", 32'(valid), 32'd0);
   endtask

   initial begin
      sys_rstn  = 1'b0;
      slave_req = 4'b0000;
      cmd_ack   = 1'b0;
      wr_done   = 1'b0;
      m_req     = 4'b0010;
      waddr_bus = {23'h300300, 23'h200200, 23'h100100, 23'h000100};
      len_bus   = {10'd40, 10'd30, 10'd20, 10'd256};
      #3;
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_cmd_req", 32'(cmd_req), 32'd0);
      chk("rst_addr", 32'(waddr), 32'd0);
      chk("rst_len", 32'(wlen), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      tick();
      tick();
      sys_rstn = 1'b1;

      // Masked slave 1 must never be granted.
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("mask_busy", 32'(m_busy), 32'd0);
         chk("mask_valid", 32'(m_valid), 32'd0);
      end

      // Single request with grant latency, stability and holdoff.
      slave_req = 4'b0001;
      tick();
      chk("lat_valid_n1", 32'(valid), 32'd0);
      chk("lat_busy_n1", 32'(busy), 32'd1);
      tick();
      chk("single_valid", 32'(valid), 32'b0001);
      chk("single_bank", 32'(wrbank), 32'd0);
      chk("single_addr", 32'(waddr), 32'h000100);
      chk("single_len", 32'(wlen), 32'd256);
      chk("single_cmd_req", 32'(cmd_req), 32'd1);
      slave_req = 4'b0000;
      tick();
      chk("cmd_hold", 32'(cmd_req), 32'd1);
      cmd_ack = 1'b1;
      tick();
      cmd_ack = 1'b0;
      chk("cmd_drop", 32'(cmd_req), 32'd0);
      chk("wait_valid", 32'(valid), 32'b0001);
      waddr_bus[22:0] = 23'h7fffff;
      tick();
      chk("addr_stable", 32'(waddr), 32'h000100);
      waddr_bus[22:0] = 23'h000100;
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      chk("done_valid_drop", 32'(valid), 32'd0);
      slave_req = 4'b0001;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("holdoff_valid", 32'(valid), 32'd0);
      end
      tick();
      chk("regrant_valid", 32'(valid), 32'b0001);

      // Ack and done together collapse straight to release.
      slave_req = 4'b0000;
      cmd_ack   = 1'b1;
      wr_done   = 1'b1;
      tick();
      cmd_ack   = 1'b0;
      wr_done   = 1'b0;
      chk("ackdone_cmd_req", 32'(cmd_req), 32'd0);
      chk("ackdone_valid", 32'(valid), 32'd0);
      tick();
      chk("ackdone_cmd_req_next", 32'(cmd_req), 32'd0);
      chk("ackdone_busy", 32'(busy), 32'd1);

      // Round robin from a fresh pointer.
      do_reset();
      slave_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         serve(k % 4);
      end
      slave_req = 4'b0000;
      for (int i = 0; i < 4; i++) tick();
      chk("rr_idle", 32'(busy), 32'd0);

      // Zero-length burst on slave 2.
      len_bus[29:20] = 10'd0;
      slave_req = 4'b0100;
      wait_grant("zero_grant_wait");
      chk("zero_valid", 32'(valid), 32'b0100);
      chk("zero_cmd_req", 32'(cmd_req), 32'd0);
      slave_req = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("zero_valid_low", 32'(valid), 32'd0);
         chk("zero_cmd_req_low", 32'(cmd_req), 32'd0);
      end
      len_bus[29:20] = 10'd30;
      slave_req = 4'b1011;
      wait_grant("ptr3_grant_wait");
      chk("ptr3_valid", 32'(valid), 32'b1000);
      chk("ptr3_bank", 32'(wrbank), 32'd3);
      slave_req = 4'b0000;
      cmd_ack = 1'b1;
      tick();
      cmd_ack = 1'b0;
      tick();

      // Asynchronous reset in WAIT, then pointer restarts at 0.
      sys_rstn = 1'b0;
      #1;
      chk("arst_valid", 32'(valid), 32'd0);
      chk("arst_bank", 32'(wrbank), 32'd0);
      chk("arst_cmd_req", 32'(cmd_req), 32'd0);
      chk("arst_addr", 32'(waddr), 32'd0);
      chk("arst_len", 32'(wlen), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      #2;
      tick();
      sys_rstn = 1'b1;
      slave_req = 4'b1100;
      wait_grant("post_rst_grant_wait");
      chk("post_rst_valid", 32'(valid), 32'b0100);
      chk("post_rst_bank", 32'(wrbank), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
